// File: rtl/adc_train_pkg.sv
// Shared definitions for the ADC-trainer result stream parser: packet layout,
// error flag positions and the parser state encoding.
package adc_train_pkg;

    localparam logic [7:0] PKT_ID_DEF  = 8'hAD;
    localparam int         HDR_ID_MSB  = 63;
    localparam int         HDR_ID_LSB  = 56;
    localparam int         HDR_LEN_MSB = 15;
    localparam int         HDR_LEN_LSB = 0;

    localparam int ERR_ID    = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_TAG   = 2;
    localparam int ERR_PHASE = 3;

    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_HDR    = 3'd1,
        S_PHASE  = 3'd2,
        S_DATA   = 3'd3,
        S_DRAIN  = 3'd4,
        S_COMMIT = 3'd5
    } state_e;

    // Beats following the header: one phase beat plus two channels per data beat.
    function automatic logic [15:0] pkt_len(input int num_adc);
        return 16'(1 + num_adc / 2);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/adc_train_stream_parser_if.sv
// 64-bit AXI-Stream link carrying trainer result packets into the parser.
interface adc_train_stream_parser_if;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/train_result_ram.sv
// Simple dual-port result store: one write port, one registered read port
// returning the old word on a same-address read/write collision.
module train_result_ram #(
    parameter int  W     = 24,
    parameter int  DEPTH = 896,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/adc_train_stream_parser.sv
// Receives trainer result packets, validates them, stages per-channel mismatch
// counters and commits good packets into the [phase][adc] result RAM.
module adc_train_stream_parser
    import adc_train_pkg::*;
#(
    parameter int          NUM_ADC   = 16,
    parameter int          PHASE_POS = 56,
    parameter logic [7:0]  PKT_ID    = PKT_ID_DEF,
    parameter int          CNT_W     = 24,
    localparam int         DEPTH     = PHASE_POS * NUM_ADC,
    localparam int         AW        = $clog2(DEPTH),
    localparam int         PW        = $clog2(PHASE_POS),
    localparam int         CW        = $clog2(NUM_ADC),
    localparam int         BW        = (NUM_ADC > 2) ? $clog2(NUM_ADC / 2) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    adc_train_stream_parser_if.slave s,
    input  logic [PW-1:0]         rd_phase,
    input  logic [CW-1:0]         rd_adc,
    output logic [CNT_W-1:0]      rd_data,
    output logic [PHASE_POS-1:0]  phase_ok,
    output logic [PHASE_POS-1:0]  phase_seen,
    output logic [6:0]            last_phase,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count,
    output logic [3:0]            err_flags,
    output logic                  busy
);
    state_e               state_q, state_d;
    logic [AW-1:0]        clr_idx_q, clr_idx_d;
    logic                 drain_pend_q, drain_pend_d;
    logic [6:0]           phase_q, phase_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 tag_err_q, tag_err_d;
    logic [CNT_W-1:0]     stage_q [NUM_ADC];
    logic [CNT_W-1:0]     stage_d [NUM_ADC];
    logic [CW-1:0]        cmt_idx_q, cmt_idx_d;
    logic [PHASE_POS-1:0] phase_ok_q, phase_ok_d, phase_seen_q, phase_seen_d;
    logic [6:0]           last_phase_q, last_phase_d;
    logic [15:0]          pkt_count_q, pkt_count_d, err_count_q, err_count_d;
    logic [3:0]           err_flags_q, err_flags_d;
    logic                 busy_q, busy_d, s_tready_q, s_tready_d;

    logic                 accept_s, tag_bad_s, last_beat_s, mid_flight_s, any_nz_s, err_inc_s;
    logic                 bad_id_s, bad_len_s;
    logic [7:0]           tag_lo_exp_s, tag_hi_exp_s;
    logic [PW-1:0]        phase_idx_s;
    logic                 ram_we_s;
    logic [AW-1:0]        ram_waddr_s, rd_addr_s;
    logic [CNT_W-1:0]     ram_wdata_s;

    assign accept_s     = s.s_tvalid & s_tready_q;
    assign bad_id_s     = s.s_tdata[HDR_ID_MSB:HDR_ID_LSB] != PKT_ID;
    assign bad_len_s    = s.s_tdata[HDR_LEN_MSB:HDR_LEN_LSB] != pkt_len(NUM_ADC);
    assign tag_lo_exp_s = 8'({beat_q, 1'b0});
    assign tag_hi_exp_s = tag_lo_exp_s | 8'd1;
    assign tag_bad_s    = (s.s_tdata[31:24] != tag_lo_exp_s) || (s.s_tdata[63:56] != tag_hi_exp_s);
    assign last_beat_s  = beat_q == BW'(NUM_ADC / 2 - 1);
    assign phase_idx_s  = phase_q[PW-1:0];
    assign rd_addr_s    = AW'(rd_phase) * AW'(NUM_ADC) + AW'(rd_adc);

    // A clr that cuts a packet short must discard its remaining beats after the sweep.
    assign mid_flight_s = ((state_q == S_PHASE || state_q == S_DATA || state_q == S_DRAIN)
                           && !(accept_s && s.s_tlast))
                        || (state_q == S_HDR && accept_s && !s.s_tlast);

    // OR of all staged counters for the pass bitmap
    always_comb begin
        any_nz_s = 1'b0;
        for (int i = 0; i < NUM_ADC; i++) begin
            any_nz_s = any_nz_s | (|stage_q[i]);
        end
    end

    // next-state and datapath decode
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        drain_pend_d = drain_pend_q;
        phase_d      = phase_q;
        beat_d       = beat_q;
        tag_err_d    = tag_err_q;
        stage_d      = stage_q;
        cmt_idx_d    = cmt_idx_q;
        phase_ok_d   = phase_ok_q;
        phase_seen_d = phase_seen_q;
        last_phase_d = last_phase_q;
        pkt_count_d  = pkt_count_q;
        err_count_d  = err_count_q;
        err_flags_d  = err_flags_q;
        err_inc_s    = 1'b0;
        ram_we_s     = 1'b0;
        ram_waddr_s  = '0;
        ram_wdata_s  = '0;

        if (clr) begin
            state_d      = S_CLEAR;
            clr_idx_d    = '0;
            drain_pend_d = (state_q == S_CLEAR) ? drain_pend_q : mid_flight_s;
            phase_ok_d   = '0;
            phase_seen_d = '0;
            last_phase_d = 7'd0;
            pkt_count_d  = 16'd0;
            err_count_d  = 16'd0;
            err_flags_d  = 4'd0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = clr_idx_q;
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_d      = drain_pend_q ? S_DRAIN : S_HDR;
                        drain_pend_d = 1'b0;
                    end else begin
                        clr_idx_d = clr_idx_q + 1'b1;
                    end
                end
                S_HDR: begin
                    if (accept_s) begin
                        if (bad_id_s || bad_len_s) begin
                            err_flags_d[ERR_ID]  = err_flags_q[ERR_ID] | bad_id_s;
                            err_flags_d[ERR_LEN] = err_flags_q[ERR_LEN] | bad_len_s;
                            err_inc_s            = 1'b1;
                            state_d              = s.s_tlast ? S_HDR : S_DRAIN;
                        end else if (s.s_tlast) begin
                            err_flags_d[ERR_LEN] = 1'b1;
                            err_inc_s            = 1'b1;
                        end else begin
                            state_d = S_PHASE;
                        end
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_PHASE: begin
                    if (accept_s) begin
                        if (s.s_tlast) begin
                            err_flags_d[ERR_LEN] = 1'b1;
                            err_inc_s            = 1'b1;
                            state_d              = S_HDR;
                        end else if (32'(s.s_tdata[6:0]) >= PHASE_POS) begin
                            err_flags_d[ERR_PHASE] = 1'b1;
                            err_inc_s              = 1'b1;
                            state_d                = S_DRAIN;
                        end else begin
                            phase_d   = s.s_tdata[6:0];
                            beat_d    = '0;
                            tag_err_d = 1'b0;
                            state_d   = S_DATA;
                        end
                    end else begin
                        state_d = S_PHASE;
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        stage_d[CW'({beat_q, 1'b0})] = s.s_tdata[CNT_W-1:0];
                        stage_d[CW'({beat_q, 1'b1})] = s.s_tdata[32+CNT_W-1:32];
                        tag_err_d                    = tag_err_q | tag_bad_s;
                        err_flags_d[ERR_TAG]         = err_flags_q[ERR_TAG] | tag_bad_s;
                        beat_d                       = beat_q + 1'b1;
                        if (s.s_tlast != last_beat_s) begin
                            err_flags_d[ERR_LEN] = 1'b1;
                            err_inc_s            = 1'b1;
                            state_d              = s.s_tlast ? S_HDR : S_DRAIN;
                        end else if (s.s_tlast) begin
                            err_inc_s = tag_err_q | tag_bad_s;
                            cmt_idx_d = '0;
                            state_d   = (tag_err_q | tag_bad_s) ? S_HDR : S_COMMIT;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DRAIN: begin
                    state_d = (accept_s && s.s_tlast) ? S_HDR : S_DRAIN;
                end
                S_COMMIT: begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = AW'(phase_q) * AW'(NUM_ADC) + AW'(cmt_idx_q);
                    ram_wdata_s = stage_q[cmt_idx_q];
                    if (cmt_idx_q == CW'(NUM_ADC - 1)) begin
                        phase_seen_d[phase_idx_s] = 1'b1;
                        phase_ok_d[phase_idx_s]   = ~any_nz_s;
                        last_phase_d              = phase_q;
                        pkt_count_d               = sat_inc16(pkt_count_q);
                        state_d                   = S_HDR;
                    end else begin
                        cmt_idx_d = cmt_idx_q + 1'b1;
                    end
                end
                default: begin
                    clr_idx_d = '0;
                    state_d   = S_CLEAR;
                end
            endcase
            err_count_d = err_inc_s ? sat_inc16(err_count_q) : err_count_q;
        end

        busy_d     = (state_d == S_CLEAR) || (state_d == S_COMMIT);
        s_tready_d = (state_d == S_HDR) || (state_d == S_PHASE)
                  || (state_d == S_DATA) || (state_d == S_DRAIN);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_idx_q    <= '0;
            drain_pend_q <= 1'b0;
            phase_q      <= 7'd0;
            beat_q       <= '0;
            tag_err_q    <= 1'b0;
            cmt_idx_q    <= '0;
            phase_ok_q   <= '0;
            phase_seen_q <= '0;
            last_phase_q <= 7'd0;
            pkt_count_q  <= 16'd0;
            err_count_q  <= 16'd0;
            err_flags_q  <= 4'd0;
            busy_q       <= 1'b1;
            s_tready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            drain_pend_q <= drain_pend_d;
            phase_q      <= phase_d;
            beat_q       <= beat_d;
            tag_err_q    <= tag_err_d;
            stage_q      <= stage_d;
            cmt_idx_q    <= cmt_idx_d;
            phase_ok_q   <= phase_ok_d;
            phase_seen_q <= phase_seen_d;
            last_phase_q <= last_phase_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
            err_flags_q  <= err_flags_d;
            busy_q       <= busy_d;
            s_tready_q   <= s_tready_d;
        end
    end

    train_result_ram #(.W(CNT_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (rd_addr_s),
        .rdata (rd_data)
    );

    assign s.s_tready = s_tready_q;
    assign phase_ok   = phase_ok_q;
    assign phase_seen = phase_seen_q;
    assign last_phase = last_phase_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
    assign err_flags  = err_flags_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_adc_train_stream_parser.sv
// Directed bench for adc_train_stream_parser: model-predicted RAM contents are
// queued when a read is issued and compared when rd_data returns.
module tb_adc_train_stream_parser;
    logic        clk = 1'b0;
    logic        rst, clr;
    logic [5:0]  rd_phase;
    logic [3:0]  rd_adc;
    logic [23:0] rd_data;
    logic [55:0] phase_ok, phase_seen;
    logic [6:0]  last_phase;
    logic [15:0] pkt_count, err_count;
    logic [3:0]  err_flags;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [23:0] sb_q [$];
    logic [23:0] pc [16];
    logic [23:0] exp_ram [896];
    logic [55:0] exp_ok, exp_seen;
    logic [6:0]  exp_last;
    logic [15:0] exp_pkt, exp_err;
    logic [3:0]  exp_flags;

    adc_train_stream_parser_if s_axis ();

    adc_train_stream_parser dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .s          (s_axis),
        .rd_phase   (rd_phase),
        .rd_adc     (rd_adc),
        .rd_data    (rd_data),
        .phase_ok   (phase_ok),
        .phase_seen (phase_seen),
        .last_phase (last_phase),
        .pkt_count  (pkt_count),
        .err_count  (err_count),
        .err_flags  (err_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        s_axis.s_tdata  = d;
        s_axis.s_tlast  = l;
        s_axis.s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis.s_tready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("beat_accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        s_axis.s_tvalid = 1'b0;
        s_axis.s_tlast  = 1'b0;
    endtask

    function automatic logic [63:0] mk_beat(input int b, input logic [7:0] id,
                                            input logic [6:0] ph, input bit swap);
        int k;
        logic [7:0] tl, th;
        if (b == 0) return {id, 40'h0, 16'd9};
        if (b == 1) return {57'h0, ph};
        k  = (b - 2) % 8;
        tl = 8'(2 * k);
        th = 8'(2 * k + 1);
        if (swap && k == 0) begin
            tl = 8'd1;
            th = 8'd0;
        end
        return {th, pc[2*k+1], tl, pc[2*k]};
    endfunction

    task automatic send_pkt(input logic [7:0] id, input logic [6:0] ph, input int last_at, input bit swap);
        for (int b = 0; b <= last_at; b++) send_beat(mk_beat(b, id, ph, swap), b == last_at);
    endtask

    task automatic model_commit(input int ph);
        logic nz = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_ram[ph*16+i] = pc[i];
            nz = nz | (pc[i] != 24'd0);
        end
        exp_seen[ph] = 1'b1;
        exp_ok[ph]   = ~nz;
        exp_last     = 7'(ph);
        exp_pkt      = exp_pkt + 16'd1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 896; i++) exp_ram[i] = 24'd0;
        exp_ok = '0; exp_seen = '0; exp_last = 7'd0;
        exp_pkt = 16'd0; exp_err = 16'd0; exp_flags = 4'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(s_axis.s_tready && !busy) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    task automatic check_status(input string tag);
        wait_idle();
        chk({tag, ".phase_ok"},   64'(phase_ok),   64'(exp_ok));
        chk({tag, ".phase_seen"}, 64'(phase_seen), 64'(exp_seen));
        chk({tag, ".last_phase"}, 64'(last_phase), 64'(exp_last));
        chk({tag, ".pkt_count"},  64'(pkt_count),  64'(exp_pkt));
        chk({tag, ".err_count"},  64'(err_count),  64'(exp_err));
        chk({tag, ".err_flags"},  64'(err_flags),  64'(exp_flags));
    endtask

    task automatic read_check(input int ph, input int ch);
        rd_phase = 6'(ph);
        rd_adc   = 4'(ch);
        sb_q.push_back(exp_ram[ph*16+ch]);
        @(posedge clk);
        #1;
        chk($sformatf("rd_data[%0d][%0d]", ph, ch), 64'(rd_data), 64'(sb_q.pop_front()));
    endtask

    task automatic read_phase(input int ph);
        for (int c = 0; c < 16; c++) read_check(ph, c);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; rd_phase = 6'd0; rd_adc = 4'd0;
        s_axis.s_tdata = 64'd0; s_axis.s_tvalid = 1'b0; s_axis.s_tlast = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state and the RAM-clear sweep length
        @(negedge clk);
        chk("reset.busy",     64'(busy),            64'd1);
        chk("reset.tready",   64'(s_axis.s_tready), 64'd0);
        chk("reset.rd_data",  64'(rd_data),         64'd0);
        chk("reset.pkt",      64'(pkt_count),       64'd0);
        n = 0;
        while (!s_axis.s_tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", 64'(n), 64'd896);
        for (int p = 0; p < 56; p++) read_phase(p);
        check_status("after_reset");

        // good packet, phase 5, all counters zero
        for (int i = 0; i < 16; i++) pc[i] = 24'd0;
        send_pkt(8'hAD, 7'd5, 9, 1'b0);
        model_commit(5);
        check_status("good_p5");
        read_phase(5);

        // good packet, phase 55, ch3 = 0x1234
        for (int i = 0; i < 16; i++) pc[i] = 24'($urandom);
        pc[3] = 24'h001234;
        send_pkt(8'hAD, 7'd55, 9, 1'b0);
        model_commit(55);
        check_status("good_p55");
        read_phase(55);

        // wrong header ID, full-length packet drained
        send_pkt(8'hAE, 7'd7, 9, 1'b0);
        exp_err = exp_err + 16'd1; exp_flags[0] = 1'b1;
        check_status("bad_id");
        read_check(55, 3);
        read_check(7, 0);

        // early tlast, then a good packet is still accepted
        send_pkt(8'hAD, 7'd10, 5, 1'b0);
        exp_err = exp_err + 16'd1; exp_flags[1] = 1'b1;
        check_status("early_tlast");
        for (int i = 0; i < 16; i++) pc[i] = 24'($urandom);
        send_pkt(8'hAD, 7'd10, 9, 1'b0);
        model_commit(10);
        check_status("good_p10");
        read_phase(10);

        // phase out of range
        send_pkt(8'hAD, 7'd60, 9, 1'b0);
        exp_err = exp_err + 16'd1; exp_flags[3] = 1'b1;
        check_status("phase_60");

        // swapped channel tags on ch0/ch1: no commit
        for (int i = 0; i < 16; i++) pc[i] = 24'($urandom) | 24'd1;
        send_pkt(8'hAD, 7'd20, 9, 1'b1);
        exp_err = exp_err + 16'd1; exp_flags[2] = 1'b1;
        check_status("tag_swap");
        read_phase(20);

        // clr while committing: everything wiped, nothing partially kept
        for (int i = 0; i < 16; i++) pc[i] = 24'($urandom) | 24'd1;
        send_pkt(8'hAD, 7'd30, 9, 1'b0);
        chk("commit.busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_clear();
        check_status("clr_commit");
        read_phase(30);
        read_phase(5);
        read_check(55, 3);
        read_check(10, 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
